// File: rtl/cpu_trace_if.sv
// cpu_trace_if: record capture and field stream bus of cpu_trace_serializer.
//   rec_*  : CPU -> serializer execution record with valid/ready handshake
//   out_*  : serializer -> debug port tagged field beats with valid/ready/last
// Modports: master = CPU / debug-port side, slave = serializer side.
interface cpu_trace_if #(
    parameter int unsigned DATA_W = 8
);
    logic              rec_valid;
    logic              rec_ready;
    logic [DATA_W-1:0] rec_opcode;
    logic [DATA_W-1:0] rec_a;
    logic [DATA_W-1:0] rec_b;
    logic [DATA_W-1:0] rec_result;
    logic              rec_carry;
    logic              rec_borrow;
    logic [DATA_W-1:0] rec_pc;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [2:0]        out_tag;
    logic              out_last;

    modport master (
        output rec_valid, rec_opcode, rec_a, rec_b, rec_result,
               rec_carry, rec_borrow, rec_pc, out_ready,
        input  rec_ready, out_valid, out_data, out_tag, out_last
    );

    modport slave (
        input  rec_valid, rec_opcode, rec_a, rec_b, rec_result,
               rec_carry, rec_borrow, rec_pc, out_ready,
        output rec_ready, out_valid, out_data, out_tag, out_last
    );
endinterface

// File: rtl/cpu_trace_serializer.sv
// cpu_trace_serializer: buffers CPU execution records in a DEPTH-entry FIFO
// and streams each record one tagged field per beat with back-pressure.
// Ports:
//   clk    : clock, rising edge
//   rst    : synchronous active-high reset
//   bus    : cpu_trace_if.slave (rec_* capture handshake, out_* field stream)
//   level  : records held in the FIFO, excluding the one being streamed
// Optional feature: define TRACE_SEQ_EN to prefix each record with a tag-7
// sequence-number beat (8 beats per record instead of 7).
module cpu_trace_serializer #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    cpu_trace_if.slave            bus,
    output logic [$clog2(DEPTH):0] level
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

`ifdef TRACE_SEQ_EN
    localparam logic [2:0] FIRST_TAG = 3'd7;
`else
    localparam logic [2:0] FIRST_TAG = 3'd0;
`endif
    localparam logic [2:0] LAST_TAG = 3'd6;

    typedef struct packed {
        logic [DATA_W-1:0] opcode;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [DATA_W-1:0] result;
        logic              carry;
        logic              borrow;
        logic [DATA_W-1:0] pc;
`ifdef TRACE_SEQ_EN
        logic [DATA_W-1:0] seq;
`endif
    } rec_t;

    typedef enum logic {
        ST_IDLE,
        ST_STREAM
    } state_t;

    // Field value for a given tag; flags are zero-extended.
    function automatic logic [DATA_W-1:0] field_sel(input rec_t r, input logic [2:0] tag);
        logic [DATA_W-1:0] f;
        f = '0;
        case (tag)
            3'd0: f = r.opcode;
            3'd1: f = r.a;
            3'd2: f = r.b;
            3'd3: f = r.result;
            3'd4: f = DATA_W'(r.carry);
            3'd5: f = DATA_W'(r.borrow);
            3'd6: f = r.pc;
`ifdef TRACE_SEQ_EN
            3'd7: f = r.seq;
`else
            3'd7: f = '0;
`endif
        endcase
        return f;
    endfunction

    state_t            state_q, state_d;
    rec_t              mem_q [DEPTH];
    rec_t              mem_d [DEPTH];
    rec_t              shadow_q, shadow_d;
    rec_t              rec_in;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  count_q, count_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [2:0]        out_tag_q, out_tag_d;
    logic              out_last_q, out_last_d;
`ifdef TRACE_SEQ_EN
    logic [DATA_W-1:0] seq_q, seq_d;
`endif

    logic full;
    logic empty;
    logic push;
    logic pop;

    assign full          = (count_q == LVL_W'(DEPTH));
    assign empty         = (count_q == '0);
    assign bus.rec_ready = !full && !rst;
    assign push          = bus.rec_valid && bus.rec_ready;

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_tag   = out_tag_q;
    assign bus.out_last  = out_last_q;
    assign level         = count_q;

    // Incoming record as stored in the FIFO.
    always_comb begin
        rec_in        = '0;
        rec_in.opcode = bus.rec_opcode;
        rec_in.a      = bus.rec_a;
        rec_in.b      = bus.rec_b;
        rec_in.result = bus.rec_result;
        rec_in.carry  = bus.rec_carry;
        rec_in.borrow = bus.rec_borrow;
        rec_in.pc     = bus.rec_pc;
`ifdef TRACE_SEQ_EN
        rec_in.seq    = seq_q;
`endif
    end

    // Streamer FSM, FIFO pointers and registered beat outputs.
    always_comb begin
        state_d     = state_q;
        mem_d       = mem_q;
        shadow_d    = shadow_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_tag_d   = out_tag_q;
        out_last_d  = out_last_q;
`ifdef TRACE_SEQ_EN
        seq_d       = seq_q;
`endif
        pop         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    pop = 1'b1;
                end
            end
            ST_STREAM: begin
                if (bus.out_ready) begin
                    if (out_last_q) begin
                        if (!empty) begin
                            pop = 1'b1;
                        end else begin
                            state_d     = ST_IDLE;
                            out_valid_d = 1'b0;
                            out_last_d  = 1'b0;
                        end
                    end else begin
                        // 7 -> 0 wraps naturally in 3 bits, giving 7,0,1..6.
                        out_tag_d  = out_tag_q + 3'd1;
                        out_data_d = field_sel(shadow_q, out_tag_d);
                        out_last_d = (out_tag_d == LAST_TAG);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Pop loads the head into the shadow register and presents its first field.
        if (pop) begin
            shadow_d    = mem_q[rd_ptr_q];
            rd_ptr_d    = rd_ptr_q + PTR_W'(1);
            state_d     = ST_STREAM;
            out_valid_d = 1'b1;
            out_tag_d   = FIRST_TAG;
            out_data_d  = field_sel(mem_q[rd_ptr_q], FIRST_TAG);
            out_last_d  = 1'b0;
        end

        if (push) begin
            mem_d[wr_ptr_q] = rec_in;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
`ifdef TRACE_SEQ_EN
            seq_d           = seq_q + DATA_W'(1);
`endif
        end

        count_d = count_q + LVL_W'(push) - LVL_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mem_q       <= '{default: '0};
            shadow_q    <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_tag_q   <= '0;
            out_last_q  <= 1'b0;
`ifdef TRACE_SEQ_EN
            seq_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            mem_q       <= mem_d;
            shadow_q    <= shadow_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_tag_q   <= out_tag_d;
            out_last_q  <= out_last_d;
`ifdef TRACE_SEQ_EN
            seq_q       <= seq_d;
`endif
        end
    end
endmodule

// File: tb/tb_cpu_trace_serializer.sv
// Testbench for cpu_trace_serializer: random records checked against a
// record-list reference model that expands each captured record into beats.
`timescale 1ns/1ps
module tb_cpu_trace_serializer;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 4;
`ifdef TRACE_SEQ_EN
    localparam int BEATS = 8;
    localparam logic [2:0] FIRST_TAG = 3'd7;
`else
    localparam int BEATS = 7;
    localparam logic [2:0] FIRST_TAG = 3'd0;
`endif

    typedef struct {
        logic [7:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic       carry;
        logic       borrow;
        logic [7:0] pc;
    } rec_m_t;

    typedef struct {
        logic [2:0] tag;
        logic       last;
        logic [7:0] data;
        int         cyc;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] level;

    cpu_trace_if #(.DATA_W(DATA_W)) bus ();

    cpu_trace_serializer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus.slave),
        .level (level)
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    seq_m = 0;
    int    last_push_cyc = 0;
    beat_t exp_q[$];
    beat_t obs_q[$];
    beat_t mon_b;
    logic [7:0] mon_f [7];

    // Reference model: every accepted record expands to its beat list in
    // protocol order; every accepted beat is logged for later comparison.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            exp_q.delete();
            obs_q.delete();
            seq_m = 0;
        end else begin
            if (bus.rec_valid && bus.rec_ready) begin
                last_push_cyc = cyc;
                mon_f[0] = bus.rec_opcode;
                mon_f[1] = bus.rec_a;
                mon_f[2] = bus.rec_b;
                mon_f[3] = bus.rec_result;
                mon_f[4] = {7'b0, bus.rec_carry};
                mon_f[5] = {7'b0, bus.rec_borrow};
                mon_f[6] = bus.rec_pc;
`ifdef TRACE_SEQ_EN
                mon_b.tag = 3'd7; mon_b.last = 1'b0; mon_b.data = 8'(seq_m); mon_b.cyc = 0;
                exp_q.push_back(mon_b);
`endif
                seq_m = (seq_m + 1) % 256;
                for (int t = 0; t < 7; t++) begin
                    mon_b.tag = 3'(t); mon_b.last = (t == 6); mon_b.data = mon_f[t]; mon_b.cyc = 0;
                    exp_q.push_back(mon_b);
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                mon_b.tag = bus.out_tag; mon_b.last = bus.out_last;
                mon_b.data = bus.out_data; mon_b.cyc = cyc;
                obs_q.push_back(mon_b);
            end
        end
    end

    function automatic rec_m_t rand_rec();
        rec_m_t r;
        r.op = 8'($urandom); r.a = 8'($urandom); r.b = 8'($urandom);
        r.res = 8'($urandom); r.carry = 1'($urandom); r.borrow = 1'($urandom);
        r.pc = 8'($urandom);
        return r;
    endfunction

    task automatic push_rec(input rec_m_t r);
        bit ok;
        ok = 1'b0;
        @(posedge clk); #1;
        bus.rec_opcode = r.op; bus.rec_a = r.a; bus.rec_b = r.b; bus.rec_result = r.res;
        bus.rec_carry = r.carry; bus.rec_borrow = r.borrow; bus.rec_pc = r.pc;
        bus.rec_valid = 1'b1;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk);
            if (bus.rec_ready) ok = 1'b1;
            @(posedge clk); #1;
        end
        bus.rec_valid = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL push_timeout: rec_ready got 0 for 2000 cycles, want 1");
        end
    endtask

    task automatic wait_tag(input logic [2:0] t);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (bus.out_valid && bus.out_tag == t) ok = 1'b1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL wait_tag: tag %0d not seen in 200 cycles, want seen", t);
        end
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 5000 && !ok; i++) begin
            @(negedge clk);
            if (!bus.out_valid && level == 3'd0) ok = 1'b1;
        end
        @(posedge clk); #1;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL drain_timeout: stream still busy after 5000 cycles, want idle");
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.rec_valid = 1'b0; bus.out_ready = 1'b0;
        bus.rec_opcode = '0; bus.rec_a = '0; bus.rec_b = '0; bus.rec_result = '0;
        bus.rec_carry = 1'b0; bus.rec_borrow = 1'b0; bus.rec_pc = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks += 6;
        if (bus.rec_ready !== 1'b0) begin errors++; $display("FAIL reset_rec_ready: got %b want 0", bus.rec_ready); end
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        if (bus.out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %h want 00", bus.out_data); end
        if (bus.out_tag !== 3'd0) begin errors++; $display("FAIL reset_out_tag: got %0d want 0", bus.out_tag); end
        if (bus.out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %b want 0", bus.out_last); end
        if (level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", level); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.rec_ready !== 1'b1) begin errors++; $display("FAIL post_reset_rec_ready: got %b want 1", bus.rec_ready); end
    endtask

    task automatic test_single();
        rec_m_t     r;
        logic [7:0] want [7];
        int         off;
        want = '{8'h12, 8'hFB, 8'h05, 8'h00, 8'h01, 8'h00, 8'h07};
        off = BEATS - 7;
        r.op = 8'h12; r.a = 8'hFB; r.b = 8'h05; r.res = 8'h00;
        r.carry = 1'b1; r.borrow = 1'b0; r.pc = 8'h07;
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        push_rec(r);
        wait_idle();
        checks++;
        if (obs_q.size() != BEATS) begin
            errors++;
            $display("FAIL single_count: got %0d beats want %0d", obs_q.size(), BEATS);
        end else begin
            for (int i = 0; i < 7; i++) begin
                checks++;
                if (obs_q[off+i].data !== want[i] || obs_q[off+i].tag !== 3'(i) || obs_q[off+i].last !== (i == 6)) begin
                    errors++;
                    $display("FAIL single_beat%0d: got tag %0d data %h last %b want tag %0d data %h last %b",
                             i, obs_q[off+i].tag, obs_q[off+i].data, obs_q[off+i].last, i, want[i], (i == 6));
                end
            end
            checks += 2;
            if (obs_q[0].cyc - last_push_cyc != 2) begin
                errors++; $display("FAIL single_latency: got %0d cycles want 2", obs_q[0].cyc - last_push_cyc);
            end
            if (obs_q[BEATS-1].cyc - obs_q[0].cyc != BEATS - 1) begin
                errors++; $display("FAIL single_span: got %0d cycles want %0d", obs_q[BEATS-1].cyc - obs_q[0].cyc, BEATS - 1);
            end
`ifdef TRACE_SEQ_EN
            checks++;
            if (obs_q[0].tag !== 3'd7 || obs_q[0].data !== 8'h00) begin
                errors++; $display("FAIL single_seq: got tag %0d data %h want tag 7 data 00", obs_q[0].tag, obs_q[0].data);
            end
`endif
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_backpressure();
        rec_m_t r;
        r = rand_rec();
        bus.out_ready = 1'b1;
        push_rec(r);
        wait_tag(3'd1);
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_tag !== 3'd2 || bus.out_data !== r.b || bus.out_last !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: got valid %b tag %0d data %h last %b want valid 1 tag 2 data %h last 0",
                         i, bus.out_valid, bus.out_tag, bus.out_data, bus.out_last, r.b);
            end
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        wait_idle();
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL bp_count: got %0d beats want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i].tag !== exp_q[i].tag || obs_q[i].data !== exp_q[i].data || obs_q[i].last !== exp_q[i].last) begin
                errors++;
                $display("FAIL bp_beat%0d: got tag %0d data %h last %b want tag %0d data %h last %b", i,
                         obs_q[i].tag, obs_q[i].data, obs_q[i].last, exp_q[i].tag, exp_q[i].data, exp_q[i].last);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_fill();
        bus.out_ready = 1'b0;
        for (int k = 0; k < 5; k++) push_rec(rand_rec());
        @(negedge clk);
        checks += 3;
        if (level !== 3'd4) begin errors++; $display("FAIL fill_level: got %0d want 4", level); end
        if (bus.rec_ready !== 1'b0) begin errors++; $display("FAIL fill_rec_ready: got %b want 0", bus.rec_ready); end
        if (bus.out_valid !== 1'b1 || bus.out_tag !== FIRST_TAG) begin
            errors++; $display("FAIL fill_shadow: got valid %b tag %0d want valid 1 tag %0d", bus.out_valid, bus.out_tag, FIRST_TAG);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        wait_idle();
        checks++;
        if (obs_q.size() != 5 * BEATS || exp_q.size() != 5 * BEATS) begin
            errors++; $display("FAIL fill_count: got %0d beats want %0d", obs_q.size(), 5 * BEATS);
        end else begin
            checks++;
            if (obs_q[5*BEATS-1].cyc - obs_q[0].cyc != 5 * BEATS - 1) begin
                errors++; $display("FAIL fill_gaps: got span %0d want %0d", obs_q[5*BEATS-1].cyc - obs_q[0].cyc, 5 * BEATS - 1);
            end
            for (int i = 0; i < 5 * BEATS; i++) begin
                checks++;
                if (obs_q[i].tag !== exp_q[i].tag || obs_q[i].data !== exp_q[i].data || obs_q[i].last !== exp_q[i].last) begin
                    errors++;
                    $display("FAIL fill_beat%0d: got tag %0d data %h last %b want tag %0d data %h last %b", i,
                             obs_q[i].tag, obs_q[i].data, obs_q[i].last, exp_q[i].tag, exp_q[i].data, exp_q[i].last);
                end
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_simul_push_pop();
        rec_m_t r;
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) push_rec(rand_rec());
        @(negedge clk);
        checks++;
        if (level !== 3'd2) begin errors++; $display("FAIL simul_pre_level: got %0d want 2", level); end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        wait_tag(3'd5);
        @(posedge clk); #1;
        r = rand_rec();
        bus.rec_opcode = r.op; bus.rec_a = r.a; bus.rec_b = r.b; bus.rec_result = r.res;
        bus.rec_carry = r.carry; bus.rec_borrow = r.borrow; bus.rec_pc = r.pc;
        bus.rec_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.rec_ready !== 1'b1 || bus.out_last !== 1'b1) begin
            errors++; $display("FAIL simul_align: got rec_ready %b out_last %b want 1 1", bus.rec_ready, bus.out_last);
        end
        @(posedge clk); #1;
        bus.rec_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (level !== 3'd2) begin errors++; $display("FAIL simul_level: got %0d want 2", level); end
        wait_idle();
        checks++;
        if (obs_q.size() != 4 * BEATS || obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL simul_count: got %0d beats want %0d", obs_q.size(), 4 * BEATS);
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i].tag !== exp_q[i].tag || obs_q[i].data !== exp_q[i].data || obs_q[i].last !== exp_q[i].last) begin
                errors++;
                $display("FAIL simul_beat%0d: got tag %0d data %h last %b want tag %0d data %h last %b", i,
                         obs_q[i].tag, obs_q[i].data, obs_q[i].last, exp_q[i].tag, exp_q[i].data, exp_q[i].last);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_reset_mid_record();
        bus.out_ready = 1'b0;
        for (int k = 0; k < 2; k++) push_rec(rand_rec());
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        wait_tag(3'd2);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.out_tag !== 3'd3) begin errors++; $display("FAIL rstmid_tag: got %0d want 3", bus.out_tag); end
        @(negedge clk);
        checks += 3;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b want 0", bus.out_valid); end
        if (level !== 3'd0) begin errors++; $display("FAIL rstmid_level: got %0d want 0", level); end
        if (bus.out_tag !== 3'd0 || bus.out_last !== 1'b0) begin
            errors++; $display("FAIL rstmid_outs: got tag %0d last %b want 0 0", bus.out_tag, bus.out_last);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        push_rec(rand_rec());
        wait_idle();
        checks++;
        if (obs_q.size() != BEATS || exp_q.size() != BEATS) begin
            errors++; $display("FAIL rstmid_count: got %0d beats want %0d", obs_q.size(), BEATS);
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i].tag !== exp_q[i].tag || obs_q[i].data !== exp_q[i].data || obs_q[i].last !== exp_q[i].last) begin
                errors++;
                $display("FAIL rstmid_beat%0d: got tag %0d data %h last %b want tag %0d data %h last %b", i,
                         obs_q[i].tag, obs_q[i].data, obs_q[i].last, exp_q[i].tag, exp_q[i].data, exp_q[i].last);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_random_traffic();
        bit done;
        done = 1'b0;
        fork
            begin
                for (int k = 0; k < 40; k++) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    push_rec(rand_rec());
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        bus.out_ready = 1'b1;
        wait_idle();
        checks++;
        if (obs_q.size() != 40 * BEATS || obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL rand_count: got %0d beats want %0d", obs_q.size(), 40 * BEATS);
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i].tag !== exp_q[i].tag || obs_q[i].data !== exp_q[i].data || obs_q[i].last !== exp_q[i].last) begin
                errors++;
                $display("FAIL rand_beat%0d: got tag %0d data %h last %b want tag %0d data %h last %b", i,
                         obs_q[i].tag, obs_q[i].data, obs_q[i].last, exp_q[i].tag, exp_q[i].data, exp_q[i].last);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

`ifdef TRACE_SEQ_EN
    task automatic test_seq_wrap();
        int n7;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 258; k++) push_rec(rand_rec());
        wait_idle();
        n7 = 0;
        for (int i = 0; i < obs_q.size(); i++) begin
            if (obs_q[i].tag == 3'd7) begin
                checks++;
                if (obs_q[i].data !== 8'(n7 % 256) || (i % 8) != 0) begin
                    errors++; $display("FAIL seq_value%0d: got %h at beat %0d want %h at beat %0d",
                                       n7, obs_q[i].data, i, 8'(n7 % 256), n7 * 8);
                end
                n7++;
            end
        end
        checks++;
        if (n7 != 258 || obs_q.size() != 258 * 8) begin
            errors++; $display("FAIL seq_count: got %0d seq beats %0d total want 258 and 2064", n7, obs_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i].tag !== exp_q[i].tag || obs_q[i].data !== exp_q[i].data || obs_q[i].last !== exp_q[i].last) begin
                errors++;
                $display("FAIL seq_beat%0d: got tag %0d data %h last %b want tag %0d data %h last %b", i,
                         obs_q[i].tag, obs_q[i].data, obs_q[i].last, exp_q[i].tag, exp_q[i].data, exp_q[i].last);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_fill();
        test_simul_push_pop();
        test_reset_mid_record();
        test_random_traffic();
`ifdef TRACE_SEQ_EN
        test_seq_wrap();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
